// File: rtl/bus_ctrl_pkg.sv
// Bus controller state encoding, request classes and block-offset constants.
package bus_ctrl_pkg;
    typedef enum logic [3:0] {
        IDLE, ARB, SNOOP, WB1, WB2, RAMLD1, RAMLD2, INV, WB_ONLY, IFETCH
    } bus_state_t;

    // Bit position in a request vector equals the class; higher wins.
    typedef enum logic [1:0] {
        CLS_IF = 2'd0,
        CLS_RD = 2'd1,
        CLS_WB = 2'd2,
        CLS_CC = 2'd3
    } req_cls_t;

    localparam int NCLS        = 4;
    localparam int BLK_OFF_BIT = 2;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types used across the dual-core system.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter_2.sv
// Two-way arbiter: highest request class wins, ties go to the rr pointer.
// Combinational grant; rr pointer registered and moved to ~last_gnt on adv.
// No backpressure: requesters simply hold their request until served.
module rr_arbiter_2
    import bus_ctrl_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic [NCLS-1:0] req0,
    input  logic [NCLS-1:0] req1,
    input  logic            adv,
    input  logic            last_gnt,
    output logic            gnt_vld,
    output logic            gnt,
    output logic [1:0]      gnt_cls
);
    logic rr_q, rr_d;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = rr_q;
        gnt_cls = 2'd0;
        // Ascending scan so the highest populated class is the one kept.
        for (int k = 0; k < NCLS; k++) begin
            if (req0[k] || req1[k]) begin
                gnt_vld = 1'b1;
                gnt_cls = 2'(k);
                gnt     = (req0[k] && req1[k]) ? rr_q : req1[k];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (adv) begin
            rr_d = ~last_gnt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// MSI coherence/memory controller: arbitrates two cores' I/D caches onto one RAM port.
// Latency: IDLE->ARB->service state; each word completes on ramstate==ACCESS.
// Backpressure: waiting requesters see iwait/dwait high; ERROR is treated as BUSY.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
    import bus_ctrl_pkg::*;
#(
    parameter int CPUS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS-1:0][31:0] dload,
    input  logic [CPUS-1:0]      cctrans,
    input  logic [CPUS-1:0]      ccwrite,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);
    localparam word_t BLK_MASK = ~(word_t'(BLKWORDS - 1) << BLK_OFF_BIT);

    bus_state_t state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       req_write_q, req_write_d;
    logic       cc_q, cc_d;
    logic       inv_done_q, inv_done_d;
    word_t      snoop_addr_q, snoop_addr_d;

    logic                  ram_done;
    logic                  other;
    logic                  txn_done;
    logic                  arb_vld, arb_gnt;
    logic [1:0]            arb_cls;
    logic [CPUS-1:0]       inv_mask;
    logic [CPUS-1:0][NCLS-1:0] req_vec;

    assign ram_done = (ramstate == ACCESS);
    assign other    = ~gnt_q;
    assign txn_done = (state_q != IDLE) && (state_q != ARB) && (state_d == IDLE);

    // The upgrade requester drops cctrans a cycle after INV; ignore it meanwhile.
    always_comb begin
        inv_mask        = '0;
        inv_mask[gnt_q] = inv_done_q;
        for (int c = 0; c < CPUS; c++) begin
            req_vec[c]         = '0;
            req_vec[c][CLS_CC] = cctrans[c] && !inv_mask[c];
            req_vec[c][CLS_WB] = dWEN[c] && !cctrans[c];
            req_vec[c][CLS_RD] = dREN[c] && !cctrans[c];
            req_vec[c][CLS_IF] = iREN[c];
        end
    end

    rr_arbiter_2 u_arb (
        .CLK      (CLK),
        .nRST     (nRST),
        .req0     (req_vec[0]),
        .req1     (req_vec[1]),
        .adv      (txn_done),
        .last_gnt (gnt_q),
        .gnt_vld  (arb_vld),
        .gnt      (arb_gnt),
        .gnt_cls  (arb_cls)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        req_write_d  = req_write_q;
        cc_d         = cc_q;
        snoop_addr_d = snoop_addr_q;
        inv_done_d   = 1'b0;
        iwait        = '1;
        dwait        = '1;
        iload        = '0;
        dload        = '0;
        ccwait       = '0;
        ccinv        = '0;
        ccsnoopaddr  = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        if (cc_q && (state_q inside {SNOOP, WB1, WB2, RAMLD1, RAMLD2, INV})) begin
            ccwait[other]      = 1'b1;
            ccsnoopaddr[other] = snoop_addr_q;
        end

        case (state_q)
            IDLE: begin
                if (arb_vld) state_d = ARB;
            end
            ARB: begin
                if (!arb_vld) begin
                    state_d = IDLE;
                end else begin
                    gnt_d        = arb_gnt;
                    req_write_d  = ccwrite[arb_gnt];
                    snoop_addr_d = daddr[arb_gnt] & BLK_MASK;
                    cc_d         = 1'b0;
                    case (req_cls_t'(arb_cls))
                        CLS_CC: begin
                            state_d               = SNOOP;
                            cc_d                  = 1'b1;
                            ccwait[~arb_gnt]      = 1'b1;
                            ccsnoopaddr[~arb_gnt] = daddr[arb_gnt] & BLK_MASK;
                        end
                        CLS_WB:  state_d = WB_ONLY;
                        CLS_RD:  state_d = RAMLD1;
                        default: state_d = IFETCH;
                    endcase
                end
            end
            SNOOP: begin
                if (ccwrite[other]) begin
                    state_d      = WB1;
                    ccinv[other] = req_write_q;
                end else if (dREN[gnt_q]) begin
                    state_d      = RAMLD1;
                    ccinv[other] = req_write_q;
                end else begin
                    state_d = INV;
                end
            end
            WB1, WB2: begin
                // Snooped core's write-back goes to RAM and straight to the requester.
                ramWEN       = 1'b1;
                ramaddr      = daddr[other];
                ramstore     = dstore[other];
                dload[gnt_q] = dstore[other];
                if (ram_done) begin
                    dwait[gnt_q] = 1'b0;
                    dwait[other] = 1'b0;
                    state_d      = (state_q == WB1) ? WB2 : IDLE;
                end
            end
            RAMLD1, RAMLD2: begin
                ramREN       = 1'b1;
                ramaddr      = daddr[gnt_q];
                dload[gnt_q] = ramload;
                if (ram_done) begin
                    dwait[gnt_q] = 1'b0;
                    state_d      = (state_q == RAMLD1) ? RAMLD2 : IDLE;
                end
            end
            INV: begin
                ccinv[other] = req_write_q;
                inv_done_d   = 1'b1;
                state_d      = IDLE;
            end
            WB_ONLY: begin
                if (!dWEN[gnt_q]) begin
                    state_d = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[gnt_q];
                    ramstore = dstore[gnt_q];
                    if (ram_done) dwait[gnt_q] = 1'b0;
                end
            end
            IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[gnt_q];
                iload[gnt_q] = ramload;
                if (ram_done) begin
                    iwait[gnt_q] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            req_write_q  <= 1'b0;
            cc_q         <= 1'b0;
            inv_done_q   <= 1'b0;
            snoop_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            req_write_q  <= req_write_d;
            cc_q         <= cc_d;
            inv_done_q   <= inv_done_d;
            snoop_addr_q <= snoop_addr_d;
        end
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: stimulus queues expected responses, a monitor checks them.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    coherence_bus_ctrl #(.CPUS(2), .BLKWORDS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    // RAM model: two BUSY (or ERROR) cycles then one ACCESS cycle per word.
    logic [31:0] mem [0:255];
    int          ram_cnt = 0;
    logic        ram_err;

    assign ramstate = (ramREN || ramWEN) ?
                      ((ram_cnt == 2) ? 2'(ACCESS) : (ram_err ? 2'(ERROR) : 2'(BUSY))) : 2'(FREE);
    assign ramload  = mem[ramaddr[9:2]];

    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ram_cnt != 2) ram_cnt <= ram_cnt + 1;
        else                                    ram_cnt <= 0;
        if (!nRST) begin
            mem[8'h40] <= 32'hDEADBEEF;
            mem[8'h80] <= 32'hA5A50000;
            mem[8'h81] <= 32'hA5A50001;
            mem[8'hC0] <= 32'hCAFEF00D;
        end else if (ramWEN && ramstate == 2'(ACCESS)) begin
            mem[ramaddr[9:2]] <= ramstore;
        end
    end

    typedef struct { logic core; logic [31:0] data; } ie_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } re_t;
    ie_t         iq[$];
    re_t         rq[$];
    logic [31:0] dq0[$], dq1[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h want no response", name, act);
    endtask

    function automatic logic sig(input int which, input int c);
        case (which)
            0:       return iwait[c];
            1:       return dwait[c];
            2:       return ccwait[c];
            default: return ccinv[c];
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int c, input logic lvl);
        int n = 0;
        @(negedge CLK);
        while (sig(which, c) !== lvl && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (sig(which, c) !== lvl) begin
            total++;
            bad++;
            $display("FAIL %s: timeout got %b want %b", name, sig(which, c), lvl);
        end
    endtask

    task automatic monitor();
        ie_t         ie;
        re_t         re;
        logic [31:0] d;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                for (int c = 0; c < 2; c++) begin
                    if (!iwait[c]) begin
                        if (iq.size() == 0) unexpected("ifetch_extra", iload[c]);
                        else begin
                            ie = iq.pop_front();
                            check("ifetch_core", 64'(c), 64'(ie.core));
                            check("ifetch_data", 64'(iload[c]), 64'(ie.data));
                        end
                    end
                end
                if (!dwait[0]) begin
                    if (dq0.size() == 0) unexpected("dload0_extra", dload[0]);
                    else begin d = dq0.pop_front(); check("dload0", 64'(dload[0]), 64'(d)); end
                end
                if (!dwait[1]) begin
                    if (dq1.size() == 0) unexpected("dload1_extra", dload[1]);
                    else begin d = dq1.pop_front(); check("dload1", 64'(dload[1]), 64'(d)); end
                end
                if ((ramREN || ramWEN) && ramstate == 2'(ACCESS)) begin
                    if (rq.size() == 0) unexpected("ram_extra", ramaddr);
                    else begin
                        re = rq.pop_front();
                        check("ram_we", 64'(ramWEN), 64'(re.we));
                        check("ram_addr", 64'(ramaddr), 64'(re.addr));
                        if (re.we) check("ram_data", 64'(ramstore), 64'(re.data));
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iwait"}, 64'(iwait), 64'(2'b11));
        check({tag, "_dwait"}, 64'(dwait), 64'(2'b11));
        check({tag, "_ccwait"}, 64'(ccwait), 64'(0));
        check({tag, "_ccinv"}, 64'(ccinv), 64'(0));
        check({tag, "_ramop"}, 64'({ramREN, ramWEN}), 64'(0));
        check({tag, "_ramaddr"}, 64'(ramaddr), 64'(0));
        check({tag, "_ramstore"}, 64'(ramstore), 64'(0));
        check({tag, "_loads"}, 64'(|{iload, dload}), 64'(0));
        check({tag, "_snoopaddr"}, 64'(|ccsnoopaddr), 64'(0));
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    task automatic stimulus();
        int inv_cnt, saw_wait, ram_ops;
        clear_inputs();
        ram_err = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        #1 nRST = 1'b1;
        @(negedge CLK); #1;

        // T1: single ifetch, core1 untouched
        iREN[0] = 1'b1; iaddr[0] = 32'h100;
        iq.push_back('{1'b0, 32'hDEADBEEF});
        rq.push_back('{1'b0, 32'h100, 32'h0});
        wait_for("t1_iwait0", 0, 0, 1'b0);
        #1 iREN[0] = 1'b0;

        // T2: read miss, snooped core clean; RAM reports ERROR while busy
        ram_err = 1'b1;
        cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h200;
        dq0.push_back(32'hA5A50000); dq0.push_back(32'hA5A50001);
        rq.push_back('{1'b0, 32'h200, 32'h0}); rq.push_back('{1'b0, 32'h204, 32'h0});
        wait_for("t2_ccwait1", 2, 1, 1'b1);
        check("t2_snoopaddr1", 64'(ccsnoopaddr[1]), 64'(32'h200));
        @(negedge CLK);
        check("t2_ccinv1", 64'(ccinv[1]), 64'(0));
        check("t2_ccwait1_hold", 64'(ccwait[1]), 64'(1));
        wait_for("t2_word0", 1, 0, 1'b0);
        #1 daddr[0] = 32'h204;
        wait_for("t2_word1", 1, 0, 1'b0);
        #1 begin cctrans[0] = 1'b0; dREN[0] = 1'b0; ram_err = 1'b0; end
        wait_for("t2_ccwait1_drop", 2, 1, 1'b0);

        // T3: write miss by core1, core0 holds M and forwards
        #1;
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h200;
        dq1.push_back(32'h11); dq1.push_back(32'h22);
        dq0.push_back(32'h0);  dq0.push_back(32'h0);
        rq.push_back('{1'b1, 32'h200, 32'h11}); rq.push_back('{1'b1, 32'h204, 32'h22});
        wait_for("t3_ccwait0", 2, 0, 1'b1);
        check("t3_snoopaddr0", 64'(ccsnoopaddr[0]), 64'(32'h200));
        #1 begin ccwrite[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h11; end
        @(negedge CLK);
        check("t3_ccinv0", 64'(ccinv[0]), 64'(1));
        wait_for("t3_word0", 1, 1, 1'b0);
        #1 begin daddr[0] = 32'h204; dstore[0] = 32'h22; daddr[1] = 32'h204; end
        wait_for("t3_word1", 1, 1, 1'b0);
        #1 clear_inputs();
        wait_for("t3_ccwait0_drop", 2, 0, 1'b0);

        // T5: ifetch ties, twice; core0 then core1 each round
        for (int r = 0; r < 2; r++) begin
            #1;
            iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h300;
            iq.push_back('{1'b0, 32'hDEADBEEF}); iq.push_back('{1'b1, 32'hCAFEF00D});
            rq.push_back('{1'b0, 32'h100, 32'h0}); rq.push_back('{1'b0, 32'h300, 32'h0});
            wait_for("t5_first", 0, 0, 1'b0);
            #1 iREN[0] = 1'b0;
            wait_for("t5_second", 0, 1, 1'b0);
            #1 iREN[1] = 1'b0;
        end

        // T4: S->M upgrade, invalidate only
        #1;
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h204;
        inv_cnt = 0; saw_wait = 0; ram_ops = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            if (ccwait[1]) saw_wait = 1;
            if (ramREN || ramWEN) ram_ops++;
            if (ccinv[1]) begin
                inv_cnt++;
                check("t4_inv_addr", 64'(ccsnoopaddr[1]), 64'(32'h200));
                #1 begin cctrans[0] = 1'b0; ccwrite[0] = 1'b0; end
            end
        end
        check("t4_inv_cycles", 64'(inv_cnt), 64'(1));
        check("t4_ccwait_seen", 64'(saw_wait), 64'(1));
        check("t4_no_ram", 64'(ram_ops), 64'(0));

        // T6: reset during WB2
        #1;
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h200;
        dq1.push_back(32'h33); dq0.push_back(32'h0);
        rq.push_back('{1'b1, 32'h200, 32'h33});
        wait_for("t6_ccwait0", 2, 0, 1'b1);
        #1 begin ccwrite[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h33; end
        wait_for("t6_word0", 1, 1, 1'b0);
        #1 begin daddr[0] = 32'h204; dstore[0] = 32'h44; daddr[1] = 32'h204; end
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1 check_reset_outputs("t6_rst");
        clear_inputs();
        repeat (2) @(negedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        check("t6_no_ramop", 64'({ramREN, ramWEN}), 64'(0));
        #1;
        iREN[1] = 1'b1; iaddr[1] = 32'h300;
        iq.push_back('{1'b1, 32'hCAFEF00D});
        rq.push_back('{1'b0, 32'h300, 32'h0});
        wait_for("t6_fresh", 0, 1, 1'b0);
        #1 iREN[1] = 1'b0;

        repeat (4) @(negedge CLK);
        check("left_iq", 64'(iq.size()), 64'(0));
        check("left_dq0", 64'(dq0.size()), 64'(0));
        check("left_dq1", 64'(dq1.size()), 64'(0));
        check("left_rq", 64'(rq.size()), 64'(0));
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #200000;
                total++;
                bad++;
                $display("FAIL global_timeout: got running want finished");
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
